avg_sched: RTL
==============

# avg_sched

Shared moving-average engine with a round-robin scheduler. Four requester channels each own an independent 8-sample window. One adder datapath is time-multiplexed between the channels. Each accepted sample updates that channel's window and produces that channel's 8-sample average (truncating sum/8) on a single backpressured output port. It sits between the sample sources and the downstream consumer, and replaces four separate 8-tap averagers.

## Interface
- NCH, 4: number of requester channels (fixed at 4; out_ch is 2 bits).
- WIDTH, 8: sample and average width.
- clk  in  1  rising-edge clock.
- rs_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of all windows, sums, pointers and any pending output.
- req_valid  in  NCH  per-channel sample valid.
- req_data  in  NCH*WIDTH  per-channel sample; channel i occupies bits [8i+7:8i].
- req_ready  out  NCH  per-channel accept; one-hot or zero.
- out_valid  out  1  average valid.
- out_ch  out  2  channel the average belongs to.
- out_avg  out  WIDTH  average value.
- out_ready  in  1  consumer accept.
- busy  out  1  high in CALC or OUT state.

## Operation
- Per-channel state:
  - hist[ch][0..7], 8-bit entries.
  - wp[ch], 3-bit write pointer.
  - sum[ch], 11-bit running sum.
  - All are zero after reset or clr.
- rr_ptr (2-bit) holds the highest-priority channel.
- FSM states: ARB, CALC, OUT.
- ARB:
  - Winner = first channel with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod 4.
  - req_ready[winner]=1, combinational in this cycle only. That cycle is the handshake.
  - Capture req_data[winner] and winner index. Go to CALC.
  - If no req_valid, stay in ARB with req_ready=0.
- CALC:
  - sum[ch] <= sum[ch] + data - hist[ch][wp[ch]].
  - hist[ch][wp[ch]] <= data.
  - wp[ch] <= wp[ch]+1, wrapping 7->0.
  - out_avg <= new sum[10:3]; out_ch <= ch; out_valid <= 1. Go to OUT.
- OUT:
  - Hold out_valid, out_avg and out_ch stable.
  - When out_ready=1: out_valid <= 0, rr_ptr <= ch+1 mod 4, go to ARB.
- Arithmetic:
  - sum never exceeds 8*255 = 2040, so 11 bits never overflow.
  - Subtraction is exact because the subtracted entry is always contained in sum.
  - Before 8 samples arrive, the window includes zeros: average = (sum of received samples)/8, truncated.
- req_ready is never asserted in CALC or OUT, or while clr=1.
- Requester rule: hold req_valid and req_data stable until req_ready is seen. Withdrawing early is illegal.
- clr=1 (synchronous, priority over everything except rs_n):
  - Zero all per-channel state and rr_ptr.
  - out_valid <= 0; state <= ARB.
  - A pending or in-flight average is discarded.
- Reset values (rs_n=0):
  - out_valid=0, out_ch=0, out_avg=0, req_ready=0, busy=0.
  - rr_ptr=0, state=ARB, all hist, wp and sum = 0.

## Timing
- Handshake in cycle T (ARB, req_ready high).
- CALC in T+1.
- out_valid=1 from T+2.
- With out_ready held high, out_valid lasts exactly cycle T+2. ARB is in T+3, so the next handshake is at T+3.
- Maximum throughput: one sample per 3 cycles, aggregate over all channels.
- out_ready is sampled only while out_valid=1. out_ready high in ARB or CALC has no effect.
- Simultaneous requests: exactly one grant per ARB cycle. Losing requesters keep waiting, with req_ready=0.
- Fairness: with all four channels continuously valid, grants rotate in order with no starvation. A channel waits at most 3 other grants.
- rs_n asserted in any state forces the reset values immediately, without waiting for a clock edge. Release is synchronous to clk.

## Test plan
- Channel 0 only: value 80 sent 9 times, out_ready=1 -> out_avg 10, 20, 30, 40, 50, 60, 70, 80, 80. out_ch=0 every time.
- All req_valid held 1, out_ready=1 after reset -> grant order 0,1,2,3,0,1. Handshakes 3 cycles apart. out_ch follows the same order.
- Channel 1: 255 eight times, then 0 -> out_avg 31, 63, 95, 127, 159, 191, 223, 255, then 223 (1785>>3). Channel 2 is interleaved throughout and is unaffected: its value 8 gives out_avg 1.
- Backpressure: out_ready=0 for 5 cycles in OUT, with channels 0-3 valid -> out_valid, out_avg and out_ch stay stable, req_ready=0 throughout. Raising out_ready gives exactly one transfer.
- clr pulsed while in OUT holding avg 80 for channel 0 -> out_valid=0 next cycle. Next channel-0 sample of 64 -> out_avg 8 and the grant starts at channel 0.
- rs_n pulled low mid-CALC (asynchronous, between edges) -> out_valid and req_ready drop immediately. After release, channel 3 sample 16 -> out_avg 2.

Source files
------------

// File: rtl/avg_sched.sv
// avg_sched: four-channel 8-sample moving averager sharing one adder under a round-robin scheduler
module avg_sched #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rs_n,
    input  logic                 clr,
    input  logic [NCH-1:0]       req_valid,
    input  logic [NCH*WIDTH-1:0] req_data,
    output logic [NCH-1:0]       req_ready,
    output logic                 out_valid,
    output logic [1:0]           out_ch,
    output logic [WIDTH-1:0]     out_avg,
    input  logic                 out_ready,
    output logic                 busy
);
    localparam int SW = WIDTH + 3;

    typedef enum logic [1:0] {ARB, CALC, OUT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       ch_q, ch_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] hist_q [NCH][8];
    logic [WIDTH-1:0] hist_d [NCH][8];
    logic [2:0]       wp_q [NCH];
    logic [2:0]       wp_d [NCH];
    logic [SW-1:0]    sum_q [NCH];
    logic [SW-1:0]    sum_d [NCH];
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_ch_q, out_ch_d;
    logic [WIDTH-1:0] out_avg_q, out_avg_d;
    logic [WIDTH-1:0] req_vec [NCH];
    logic [1:0]       win;
    logic             win_vld;
    logic [SW-1:0]    new_sum;

    for (genvar g = 0; g < NCH; g++) begin : g_slice
        assign req_vec[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Round-robin search: lowest offset from rr_ptr with a valid request wins
    always_comb begin
        win     = rr_ptr_q;
        win_vld = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_valid[rr_ptr_q + 2'(k)]) begin
                win     = rr_ptr_q + 2'(k);
                win_vld = 1'b1;
            end
        end
    end

    // The oldest entry leaves the window as the new sample enters
    assign new_sum = sum_q[ch_q] + SW'(data_q) - SW'(hist_q[ch_q][wp_q[ch_q]]);

    assign req_ready = (rs_n && !clr && state_q == ARB && win_vld) ? NCH'(1) << win : '0;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_avg   = out_avg_q;
    assign busy      = state_q != ARB;

    // Next-state and datapath update for the shared averaging engine
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        ch_d        = ch_q;
        data_d      = data_q;
        hist_d      = hist_q;
        wp_d        = wp_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_avg_d   = out_avg_q;
        if (clr) begin
            state_d     = ARB;
            rr_ptr_d    = '0;
            hist_d      = '{default: '0};
            wp_d        = '{default: '0};
            sum_d       = '{default: '0};
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ARB: begin
                    if (win_vld) begin
                        ch_d    = win;
                        data_d  = req_vec[win];
                        state_d = CALC;
                    end
                end
                CALC: begin
                    sum_d[ch_q]              = new_sum;
                    hist_d[ch_q][wp_q[ch_q]] = data_q;
                    wp_d[ch_q]               = wp_q[ch_q] + 3'd1;
                    out_avg_d                = new_sum[SW-1:3];
                    out_ch_d                 = ch_q;
                    out_valid_d              = 1'b1;
                    state_d                  = OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        rr_ptr_d    = ch_q + 2'd1;
                        state_d     = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    // All state registers, cleared asynchronously by rs_n
    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            ch_q        <= '0;
            data_q      <= '0;
            hist_q      <= '{default: '0};
            wp_q        <= '{default: '0};
            sum_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_avg_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            ch_q        <= ch_d;
            data_q      <= data_d;
            hist_q      <= hist_d;
            wp_q        <= wp_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_avg_q   <= out_avg_d;
        end
    end
endmodule
